conv_operand_loader: RTL

CONV_OPERAND_LOADER -- requirements
Module: conv_operand_loader

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_seg_buffer.sv | 50 +++++
 rtl/conv_operand_loader.sv | 115 +++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants, loader state encoding and the word/buffer types used by the
// operand loader and the downstream convolution stage.
package conv_pkg;

    localparam int CONV_WORD_W = 64;
    localparam int CONV_DEPTH  = 256;
    localparam int CONV_LEN_W  = 8;

    typedef enum logic [1:0] {
        S_SIG = 2'd0,
        S_KER = 2'd1,
        S_OUT = 2'd2
    } state_t;

    typedef logic [0:CONV_WORD_W-1] word_t;
    typedef logic [0:CONV_DEPTH-1][0:CONV_WORD_W-1] buf_t;

endpackage

// File: rtl/conv_seg_buffer.sv
// One operand segment store: indexed write port, saturating element counter,
// sticky overflow flag and an optional whole-buffer clear.
module conv_seg_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH  = CONV_DEPTH,
    parameter int WORD_W = CONV_WORD_W,
    parameter int LEN_W  = CONV_LEN_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic                           last,
    input  logic [WORD_W-1:0]              wdata,
    input  logic                           clr,
    input  logic                           zero,
    output logic [0:DEPTH-1][0:WORD_W-1]   data,
    output logic [LEN_W-1:0]               len_inc,
    output logic                           ovf
);

    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    logic [LEN_W-1:0] cnt;
    logic             full;

    assign full    = (cnt == CNT_MAX);
    // Element count including the beat currently being written, saturated.
    assign len_inc = full ? CNT_MAX : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (we) begin
            if (full)
                ovf <= 1'b1;
            cnt <= last ? '0 : len_inc;
        end
    end

    // Beats arriving once the counter is saturated are dropped.
    always_ff @(posedge clk) begin
        if (reset || zero)
            data <= '0;
        else if (we && !full)
            data[cnt] <= wdata;
    end

endmodule

// File: rtl/conv_operand_loader.sv
// Collects a signal segment then a kernel segment from a valid/ready stream and
// presents both as one operand frame. Define CONV_LOADER_ZEROPAD_EN to zero both
// buffers on the frame handshake so unused tail entries read as 0.
module conv_operand_loader
    import conv_pkg::*;
#(
    parameter int DEPTH  = CONV_DEPTH,
    parameter int WORD_W = CONV_WORD_W,
    parameter int LEN_W  = CONV_LEN_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [WORD_W-1:0]              s_data,
    input  logic                           s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [0:DEPTH-1][0:WORD_W-1]   x1,
    output logic [0:DEPTH-1][0:WORD_W-1]   x2,
    output logic [LEN_W-1:0]               len1,
    output logic [LEN_W-1:0]               len2,
    output logic                           err_ovf,
    output logic                           err_len
);

    state_t           state;
    logic             accept;
    logic             hs;
    logic             pad_clr;
    logic [LEN_W-1:0] sig_len;
    logic [LEN_W-1:0] ker_len;
    logic             sig_ovf;
    logic             ker_ovf;

    assign accept  = s_valid && s_ready;
    assign hs      = m_valid && m_ready;
    assign err_ovf = sig_ovf | ker_ovf;

`ifdef CONV_LOADER_ZEROPAD_EN
    assign pad_clr = hs;
`else
    assign pad_clr = 1'b0;
`endif

    conv_seg_buffer #(.DEPTH(DEPTH), .WORD_W(WORD_W), .LEN_W(LEN_W)) u_sig (
        .clk     (clk),
        .reset   (reset),
        .we      (accept && state == S_SIG),
        .last    (s_last),
        .wdata   (s_data),
        .clr     (hs),
        .zero    (pad_clr),
        .data    (x1),
        .len_inc (sig_len),
        .ovf     (sig_ovf)
    );

    conv_seg_buffer #(.DEPTH(DEPTH), .WORD_W(WORD_W), .LEN_W(LEN_W)) u_ker (
        .clk     (clk),
        .reset   (reset),
        .we      (accept && state == S_KER),
        .last    (s_last),
        .wdata   (s_data),
        .clr     (hs),
        .zero    (pad_clr),
        .data    (x2),
        .len_inc (ker_len),
        .ovf     (ker_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_SIG;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            len1    <= '0;
            len2    <= '0;
            err_len <= 1'b0;
        end else begin
            case (state)
                S_SIG: begin
                    if (accept && s_last) begin
                        len1  <= sig_len;
                        state <= S_KER;
                    end
                end
                S_KER: begin
                    if (accept && s_last) begin
                        len2    <= ker_len;
                        err_len <= (ker_len > len1);
                        s_ready <= 1'b0;
                        m_valid <= 1'b1;
                        state   <= S_OUT;
                    end
                end
                S_OUT: begin
                    // Input stays closed on the handshake cycle itself.
                    if (m_ready) begin
                        err_len <= 1'b0;
                        s_ready <= 1'b1;
                        m_valid <= 1'b0;
                        state   <= S_SIG;
                    end
                end
                default: begin
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                    state   <= S_SIG;
                end
            endcase
        end
    end

endmodule
